irq_vector_ctrl: RTL
====================

Name: irq_vector_ctrl

Overview:
- Multi-channel interrupt controller; replaces the single raw interrupt line into the Processor's decode/control path.
- Synchronises and edge-detects NUM_IRQ external lines, latches pending bits, applies a mask, and picks the winning channel by fixed priority (index 0 highest).
- Presents one request plus a vector-table address to the core over a req/ack handshake.
- Tracks in-service channels until the core retires the return-from-interrupt (eoi).

Parameters:
- NUM_IRQ, 4, number of interrupt channels (1..16).
- ADDR_W, 16, width of the vector address (data-memory address width).
- VEC_BASE, 0, data-memory address of vector-table entry 0.
- VEC_STRIDE, 2, words per vector entry (32-bit PC = two 16-bit words).
- SYNC_STAGES, 2, synchroniser depth on irq_in (>=2).
- MASK_RST, all zeros, reset value of the mask register (1 = masked).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_in  in  NUM_IRQ  raw external interrupt lines, asynchronous, rising-edge triggered
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  NUM_IRQ  new mask value
- irq_ack  in  1  core accepted the request (first cycle of its INT sequence)
- eoi  in  1  one-cycle pulse: core retired an RTI
- irq_req  out  1  request to the core
- irq_id  out  $clog2(NUM_IRQ) (min 1)  winning channel
- irq_vec_addr  out  ADDR_W  VEC_BASE + irq_id*VEC_STRIDE
- mask_q  out  NUM_IRQ  current mask
- pending_q  out  NUM_IRQ  latched pending bits
- isr_q  out  NUM_IRQ  in-service bits
- overrun_q  out  NUM_IRQ  sticky: an edge arrived while that channel was already pending

Behaviour:
- Reset (async, active-high) values:
  - mask_q = MASK_RST.
  - pending_q, isr_q, overrun_q, irq_req, irq_id, irq_vec_addr = 0.
  - Synchroniser and edge flops = 0; state = IDLE.
- Edge detection:
  - edge = sync_out & ~sync_out_d.
  - On edge, pending is set at the next clock.
  - Latency from the first clk edge sampling irq_in high: pending visible after SYNC_STAGES+1 cycles; irq_req follows one cycle later when eligible.
- Masking:
  - Pending latches regardless of mask; mask only gates eligibility.
  - mask_we takes effect on the next edge.
- FSM states are IDLE, REQ and SERVICE.
  - IDLE: if any (pending & ~mask) and isr_q == 0, latch the winner's irq_id and irq_vec_addr, set irq_req, go to REQ.
  - REQ: irq_req=1; irq_id and irq_vec_addr hold stable until ack.
    - The request is not withdrawn if that channel becomes masked meanwhile.
    - On irq_ack: clear pending[id], clear overrun[id], set isr[id], drop irq_req, go to SERVICE.
  - SERVICE: on eoi, clear the highest-priority set isr bit. Go to IDLE if isr becomes 0, else stay in SERVICE.
- Simultaneous events:
  - Edge and ack on the same channel in the same cycle: the set dominates, so pending stays 1.
  - Edge while pending already 1: overrun bit set; no second pending.
  - eoi while isr_q == 0: ignored.
  - irq_ack outside REQ: ignored.
  - eoi and ack in the same cycle (nested build only): ack processed first, then eoi clears the new highest-priority isr bit.
- Arithmetic: irq_vec_addr computed in ADDR_W bits, wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: IRQ_NEST_EN.
- Defined: in SERVICE, an unmasked pending channel with priority strictly higher than the highest set isr bit causes a transition to REQ (preemption). isr_q then holds multiple bits, and eoi unwinds one bit at a time.
- Undefined: no preemption; new requests wait until isr_q == 0.

Decomposition:
- Package irq_vector_pkg: state enum (IDLE, REQ, SERVICE), ID width function, vector address function.
- Sub-module irq_prio_enc: combinational fixed-priority encoder (lowest index wins) returning valid + id. It is instantiated for pending selection and for isr highest-bit lookup.

Test Plan:
- Reset mid-REQ: assert reset while irq_req=1 -> all outputs return to reset values immediately, without waiting for clk.
- Single channel: pulse irq_in[2]=1 -> pending_q=0100 after 3 cycles, irq_req=1, irq_id=2, irq_vec_addr=4; ack -> isr_q=0100, pending_q=0; eoi -> isr_q=0, state IDLE.
- Priority: edges on channels 3 and 1 in the same cycle -> irq_id=1 first; after eoi -> irq_id=3, irq_vec_addr=6.
- Mask: mask_wdata=0010, then pulse irq_in[1] -> pending_q=0010, no irq_req; write mask 0 -> irq_req within 1 cycle.
- Overrun/collision: second edge on channel 0 while pending -> overrun_q[0]=1; edge coincident with ack on the same channel -> pending stays 1.
- IRQ_NEST_EN: in SERVICE for channel 3, pulse channel 0 -> irq_req with id 0, isr_q=1001 after ack. Two eoi pulses clear bit 0, then bit 3. Without the macro there is no request until the first eoi.

Source files
------------

// File: rtl/irq_vector_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
package irq_vector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Channel-id width, never narrower than one bit so a single-channel build still has a port.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Callers truncate the result to their address width, which gives modulo wrap.
  function automatic logic [31:0] vec_addr(input int base, input int stride, input int id);
    return 32'(base + id * stride);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  output logic           o_valid,
  output logic [IDW-1:0] o_id
);

  // Scan from the top so the lowest set index is the last write.
  always_comb begin
    o_valid = |i_req;
    o_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = IDW'(i);
    end
  end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Multi-channel vectored interrupt controller with a req/ack/eoi handshake to the core.
// Define IRQ_NEST_EN to let higher-priority channels preempt an in-service one.
module irq_vector_ctrl
  import irq_vector_pkg::*;
#(
  parameter int                 NUM_IRQ     = 4,
  parameter int                 ADDR_W      = 16,
  parameter int                 VEC_BASE    = 0,
  parameter int                 VEC_STRIDE  = 2,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] MASK_RST    = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_IRQ-1:0]               irq_in,
  input  logic                             mask_we,
  input  logic [NUM_IRQ-1:0]               mask_wdata,
  input  logic                             irq_ack,
  input  logic                             eoi,
  output logic                             irq_req,
  output logic [id_width(NUM_IRQ)-1:0]     irq_id,
  output logic [ADDR_W-1:0]                irq_vec_addr,
  output logic [NUM_IRQ-1:0]               mask_q,
  output logic [NUM_IRQ-1:0]               pending_q,
  output logic [NUM_IRQ-1:0]               isr_q,
  output logic [NUM_IRQ-1:0]               overrun_q
);

  localparam int IdW = id_width(NUM_IRQ);

  logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IRQ-1:0] r_syncD;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_isr;
  logic [NUM_IRQ-1:0] r_overrun;
  logic               r_req;
  logic [IdW-1:0]     r_id;
  logic [ADDR_W-1:0]  r_vec;
  irq_state_t         r_state;

  logic [NUM_IRQ-1:0] w_syncOut;
  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_eligible;
  logic               w_pendValid;
  logic [IdW-1:0]     w_pendId;
  logic [ADDR_W-1:0]  w_vecAddr;
  logic [NUM_IRQ-1:0] w_ackSet;
  logic [NUM_IRQ-1:0] w_isrAfterAck;
  logic               w_isrValid;
  logic [IdW-1:0]     w_isrId;
  logic [NUM_IRQ-1:0] w_eoiClr;
  logic [NUM_IRQ-1:0] w_isrNext;
  logic               w_preempt;

  assign w_syncOut  = r_sync[SYNC_STAGES-1];
  assign w_edge     = w_syncOut & ~r_syncD;
  assign w_eligible = r_pending & ~r_mask;
  assign w_vecAddr  = ADDR_W'(vec_addr(VEC_BASE, VEC_STRIDE, int'(w_pendId)));

  // An ack retires the latched request; eoi then unwinds the top isr bit including that one.
  assign w_ackSet      = (r_state == REQ && irq_ack) ? (NUM_IRQ'(1) << r_id) : '0;
  assign w_isrAfterAck = r_isr | w_ackSet;
  assign w_eoiClr      = (eoi && w_isrValid) ? (NUM_IRQ'(1) << w_isrId) : '0;
  assign w_isrNext     = w_isrAfterAck & ~w_eoiClr;

  irq_prio_enc #(.N(NUM_IRQ), .IDW(IdW)) u_pendEnc (
    .i_req   (w_eligible),
    .o_valid (w_pendValid),
    .o_id    (w_pendId)
  );

  irq_prio_enc #(.N(NUM_IRQ), .IDW(IdW)) u_isrEnc (
    .i_req   (w_isrAfterAck),
    .o_valid (w_isrValid),
    .o_id    (w_isrId)
  );

`ifdef IRQ_NEST_EN
  assign w_preempt = w_pendValid && (w_pendId < w_isrId);
`else
  assign w_preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_syncD <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_syncD <= w_syncOut;
    end
  end

  // New edges win over an ack-clear in the same cycle so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask    <= MASK_RST;
      r_pending <= '0;
      r_overrun <= '0;
      r_isr     <= '0;
    end else begin
      if (mask_we) r_mask <= mask_wdata;
      r_pending <= (r_pending & ~w_ackSet) | w_edge;
      r_overrun <= (r_overrun & ~w_ackSet) | (w_edge & r_pending);
      r_isr     <= w_isrNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_id    <= '0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pendValid && r_isr == '0) begin
            r_id    <= w_pendId;
            r_vec   <= w_vecAddr;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            r_req   <= 1'b0;
            r_state <= (w_isrNext == '0) ? IDLE : SERVICE;
          end
        end
        SERVICE: begin
          if (w_isrNext == '0) begin
            r_state <= IDLE;
          end else if (w_preempt) begin
            r_id    <= w_pendId;
            r_vec   <= w_vecAddr;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq_req      = r_req;
  assign irq_id       = r_id;
  assign irq_vec_addr = r_vec;
  assign mask_q       = r_mask;
  assign pending_q    = r_pending;
  assign isr_q        = r_isr;
  assign overrun_q    = r_overrun;

endmodule
